// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : constants and helpers shared by the UART receive/transmit paths  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Receiver state encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_par   = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;
    localparam logic [2:0] c_st_break = 3'd5;

    // 16x oversampling divisor, rounded to nearest
    function automatic int baud_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + 8 * baud) / (16 * baud));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock first-word-fall-through FIFO                       |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_count = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_full_count);
    assign count = r_count;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the head slot in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_buffered : 16x oversampled UART receiver with FWFT receive FIFO     |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clear,
    output logic [7:0]                    led
);

    localparam int         c_div      = baud_div(CLK_HZ, BAUD);
    localparam logic [3:0] c_bit_last = 4'(DATA_BITS - 1);

    logic                   w_tick;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic [2:0]             r_state;
    logic [3:0]             r_tick_cnt;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_ok;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_overrun;
    logic [7:0]             r_led;
    logic                   w_par_exp;
    logic                   w_stop_sample;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic [7:0]             w_led_word;

    generate
        if (c_div <= 1) begin : g_tick_every
            assign w_tick = 1'b1;
        end else begin : g_tick_div
            localparam int c_div_w = $clog2(c_div);
            localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
            logic [c_div_w-1:0] r_div_cnt;

            always_ff @(posedge clk) begin
                if (!reset)                     r_div_cnt <= '0;
                else if (r_div_cnt == c_div_last) r_div_cnt <= '0;
                else                            r_div_cnt <= r_div_cnt + c_div_w'(1);
            end

            assign w_tick = (r_div_cnt == c_div_last);
        end
    endgenerate

    // Preset high so reset release does not look like a start bit
    always_ff @(posedge clk) begin
        if (!reset) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    assign w_par_exp = (PARITY == PAR_ODD)  ? ~(^r_shift) :
                       (PARITY == PAR_EVEN) ?  (^r_shift) : 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_ok   <= 1'b1;
        end else if (w_tick) begin
            case (r_state)
                c_st_idle: begin
                    if (!w_rxs) begin
                        r_tick_cnt <= '0;
                        r_state    <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (r_tick_cnt == 4'd7) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_par_ok   <= 1'b1;
                        r_state    <= w_rxs ? c_st_idle : c_st_data;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                c_st_data: begin
                    if (r_tick_cnt == 4'd15) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_bit_last)
                            r_state <= (PARITY != PAR_NONE) ? c_st_par : c_st_stop;
                        else
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                c_st_par: begin
                    if (r_tick_cnt == 4'd15) begin
                        r_tick_cnt <= '0;
                        r_par_ok   <= (w_rxs == w_par_exp);
                        r_state    <= c_st_stop;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                c_st_stop: begin
                    if (r_tick_cnt == 4'd15) begin
                        r_tick_cnt <= '0;
                        r_state    <= w_rxs ? c_st_idle : c_st_break;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                    end
                end
                c_st_break: begin
                    if (w_rxs) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign w_stop_sample = w_tick && (r_state == c_st_stop) && (r_tick_cnt == 4'd15);
    assign w_push        = w_stop_sample && w_rxs && r_par_ok;
    assign w_pop         = rx_valid && rx_ready;
    assign w_accept      = w_push && (!w_full || w_pop);

    generate
        if (DATA_BITS >= 8) begin : g_led_trunc
            assign w_led_word = r_shift[7:0];
        end else begin : g_led_ext
            assign w_led_word = {{(8 - DATA_BITS){1'b0}}, r_shift};
        end
    endgenerate

    // Sticky flags: a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_led        <= '0;
        end else begin
            if (w_stop_sample && !w_rxs)        r_frame_err <= 1'b1;
            else if (err_clear)                 r_frame_err <= 1'b0;

            if (w_stop_sample && !r_par_ok)     r_parity_err <= 1'b1;
            else if (err_clear)                 r_parity_err <= 1'b0;

            if (w_push && w_full && !w_pop)     r_overrun <= 1'b1;
            else if (err_clear)                 r_overrun <= 1'b0;

            if (w_accept)                       r_led <= w_led_word;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .wr_data (r_shift),
        .pop     (w_pop),
        .rd_data (rx_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (rx_count)
    );

    assign rx_valid   = !w_empty;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign led        = r_led;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_buffered : directed bench, 8N1/depth-4 and 7O1/depth-16 DUTs    |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_uart_rx_buffered;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 3_125_000;
    localparam int BIT_T  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       line_a, ready_a, clear_a;
    logic [7:0] data_a;
    logic       valid_a;
    logic [2:0] count_a;
    logic       ferr_a, perr_a, ovr_a;
    logic [7:0] led_a;

    logic       line_b, ready_b, clear_b;
    logic [6:0] data_b;
    logic       valid_b;
    logic [4:0] count_b;
    logic       ferr_b, perr_b, ovr_b;
    logic [7:0] led_b;

    int n_total = 0;
    int n_pass  = 0;

    uart_rx_buffered #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
        .FIFO_DEPTH(4), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .uart_rx(line_a), .rx_data(data_a),
        .rx_valid(valid_a), .rx_ready(ready_a), .rx_count(count_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
        .err_clear(clear_a), .led(led_a)
    );

    uart_rx_buffered #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
        .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .reset(reset), .uart_rx(line_b), .rx_data(data_b),
        .rx_valid(valid_b), .rx_ready(ready_b), .rx_count(count_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
        .err_clear(clear_b), .led(led_b)
    );

    typedef struct {
        string      name;
        int         sel;
        logic [9:0] bits;
        int         nbits;
        int         exp_count;
        int         exp_head;
        int         exp_led;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_bit(input int sel, input logic b, input int cycles);
        if (sel == 0) line_a = b;
        else          line_b = b;
        repeat (cycles) @(negedge clk);
    endtask

    // Start bit, nbits LSB first, stop bit, short idle gap
    task automatic send_frame(input int sel, input logic [9:0] bits, input int nbits);
        drive_bit(sel, 1'b0, BIT_T);
        for (int i = 0; i < nbits; i++) drive_bit(sel, bits[i], BIT_T);
        drive_bit(sel, 1'b1, BIT_T);
        drive_bit(sel, 1'b1, 4);
    endtask

    task automatic pop_a();
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear(input int sel);
        if (sel == 0) clear_a = 1'b1; else clear_b = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        clear_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int cnt, head, ledv, perr, ferr, ferr_events;

        vecs[0] = '{"8n1_41",    0, 10'h041, 8, 1, 'h41, 'h41, 0, 0};
        vecs[1] = '{"8n1_42",    0, 10'h042, 8, 2, 'h41, 'h42, 0, 0};
        vecs[2] = '{"7o1_55_ok", 1, 10'h0D5, 8, 1, 'h55, 'h55, 0, 0};
        vecs[3] = '{"7o1_55_bad",1, 10'h055, 8, 1, 'h55, 'h55, 1, 0};
        vecs[4] = '{"7o1_0b_ok", 1, 10'h00B, 8, 2, 'h55, 'h0B, 1, 0};

        reset   = 1'b0;
        line_a  = 1'b1; ready_a = 1'b0; clear_a = 1'b0;
        line_b  = 1'b1; ready_b = 1'b0; clear_b = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", valid_a, 0);
        check("rst_count", count_a, 0);
        check("rst_data",  data_a,  0);
        check("rst_led",   led_a,   0);
        check("rst_flags", {ferr_a, perr_a, ovr_a}, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Tests 1 and 2: framed words into both receivers
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].sel, vecs[v].bits, vecs[v].nbits);
            if (vecs[v].sel == 0) begin
                cnt = count_a; head = data_a; ledv = led_a; perr = perr_a; ferr = ferr_a;
            end else begin
                cnt = count_b; head = data_b; ledv = led_b; perr = perr_b; ferr = ferr_b;
            end
            check({vecs[v].name, "_count"}, cnt,  vecs[v].exp_count);
            check({vecs[v].name, "_head"},  head, vecs[v].exp_head);
            check({vecs[v].name, "_led"},   ledv, vecs[v].exp_led);
            check({vecs[v].name, "_perr"},  perr, vecs[v].exp_perr);
            check({vecs[v].name, "_ferr"},  ferr, vecs[v].exp_ferr);
        end

        pop_a();
        check("t1_pop_head",  data_a,  'h42);
        check("t1_pop_count", count_a, 1);
        pop_a();
        check("t1_drain_valid", valid_a, 0);

        pulse_clear(1);
        check("t2_perr_cleared", perr_b,  0);
        check("t2_count_kept",   count_b, 2);

        // Test 3: line held low for three frame times
        ferr_events = 0;
        line_a = 1'b0;
        for (int c = 0; c < 3 * 10 * BIT_T; c++) begin
            @(negedge clk);
            clear_a = 1'b0;
            if (ferr_a) begin
                ferr_events++;
                clear_a = 1'b1;
            end
        end
        clear_a = 1'b0;
        line_a  = 1'b1;
        repeat (40) @(negedge clk);
        check("t3_ferr_events", ferr_events, 1);
        check("t3_no_push",     count_a,     0);
        check("t3_perr",        perr_a,      0);
        send_frame(0, 10'h03C, 8);
        check("t3_recover_head",  data_a,  'h3C);
        check("t3_recover_count", count_a, 1);
        pop_a();

        // Test 4: overrun into a depth-4 FIFO
        for (int k = 1; k <= 5; k++) send_frame(0, 10'(k), 8);
        check("t4_count_full", count_a, 4);
        check("t4_overrun",    ovr_a,   1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t4_pop_%0d", k), data_a, k);
            pop_a();
        end
        check("t4_empty", valid_a, 0);

        // Test 5: short low glitch is rejected
        pulse_clear(0);
        line_a = 1'b0;
        repeat (4) @(negedge clk);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_no_push", count_a, 0);
        check("t5_flags",   {ferr_a, perr_a, ovr_a}, 0);
        send_frame(0, 10'h099, 8);
        check("t5_after_head", data_a, 'h99);

        // Test 6: reset mid-DATA of 0xA5
        drive_bit(0, 1'b0, BIT_T);
        drive_bit(0, 1'b1, BIT_T);
        drive_bit(0, 1'b0, BIT_T);
        drive_bit(0, 1'b1, BIT_T);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_rst_valid",   valid_a, 0);
        check("t6_rst_count",   count_a, 0);
        check("t6_rst_data",    data_a,  0);
        check("t6_rst_led",     led_a,   0);
        check("t6_rst_count_b", count_b, 0);
        reset  = 1'b1;
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_stale_push", count_a, 0);
        send_frame(0, 10'h05A, 8);
        check("t6_count", count_a, 1);
        check("t6_head",  data_a,  'h5A);
        check("t6_led",   led_a,   'h5A);
        pop_a();
        check("t6_single_entry", valid_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Parametrised UART receive path: 16x-oversampled receiver with configurable data width and parity, feeding a synchronous first-word-fall-through FIFO with a valid/ready read port. Successor to the fixed 8N1 receive logic in `uart_fifo`. Sits between the board `uart_rx` pin and any downstream byte consumer. Adds framing, parity and overrun error reporting, and an 8-bit `led` mirror of the last accepted word.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate.
- `DATA_BITS`, 8, payload bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `FIFO_DEPTH`, 16, number of FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2, synchroniser flops on `uart_rx`; at least 2.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  DATA_BITS  FIFO head word; valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accept; a pop occurs when `rx_valid && rx_ready`.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `parity_err`  out  1  sticky: parity mismatch.
- `overrun`  out  1  sticky: word completed while the FIFO was full and no pop occurred.
- `err_clear`  in  1  one-cycle pulse that clears all three sticky flags.
- `led`  out  8  last word pushed into the FIFO. Zero-extended if `DATA_BITS` < 8; low 8 bits if `DATA_BITS` = 9.

## Operation
- **Reset** (`reset` = 0 at a clock edge):
  - All outputs go to 0: `rx_valid`, `rx_count`, `rx_data`, the three error flags and `led`.
  - Synchroniser flops are preset to 1.
  - FSM goes to IDLE; FIFO pointers and tick counter go to 0.
  - Reset asserted mid-frame abandons the frame; no push occurs.
- **Tick generation**:
  - DIV = (CLK_HZ + 8·BAUD) / (16·BAUD), integer division (rounds to nearest).
  - `tick` pulses for one cycle every DIV cycles and free-runs.
  - DIV = 1 gives `tick` high on every cycle.
- **Receiver FSM** (evaluated on `tick`; `rxs` is the synchronised input):
  - IDLE: when `rxs` = 0, clear the tick count and go to START.
  - START: after 8 ticks, sample `rxs`. If 1, it was a glitch: go back to IDLE. If 0, go to DATA.
  - DATA: sample every 16 ticks, LSB first, shifting into the shift register. After DATA_BITS samples, go to PAR if PARITY ≠ 0, otherwise to STOP.
  - PAR: after 16 ticks, sample the parity bit and compare with the XOR of the data bits (even mode) or its inverse (odd mode).
  - STOP: after 16 ticks, sample `rxs`.
    - `rxs` = 1 and parity OK: push the word, update `led`, go to IDLE.
    - `rxs` = 1 and parity bad: set `parity_err`, discard the word, go to IDLE.
    - `rxs` = 0: set `frame_err`, discard the word, go to BREAK. A frame that has both a parity error and a framing error sets both flags.
  - BREAK: wait for `rxs` = 1, then go to IDLE. A continuous low line therefore yields exactly one `frame_err` and no pushes.
- **FIFO**:
  - First-word-fall-through: `rx_data` shows the head word whenever `rx_valid` is high.
  - Push when full with no pop in the same cycle: the word is dropped and `overrun` is set.
  - Push and pop in the same cycle while full: both take effect and `rx_count` is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
  - A pop while empty is ignored.
- **Error flags**:
  - `err_clear` clears all sticky flags.
  - If `err_clear` and a new error event fall in the same cycle, the set wins.

## Timing
- Synchroniser latency: SYNC_STAGES cycles.
- Stop-bit sample point: (8 + 16·(DATA_BITS + P)) + 16 ticks after the first tick with `rxs` = 0, where P = 1 if PARITY ≠ 0, else 0.
- Push occurs on the cycle of the stop-bit sample. `rx_valid` and `led` update on the next clock edge.
- Pop effect: `rx_data` shows the next entry and `rx_count` decrements on the edge after `rx_valid && rx_ready`.
- Baud tolerance: receiver locks to the falling edge each frame and must accept a ±2% baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - receiver state encoding (IDLE, START, DATA, PAR, STOP, BREAK);
  - divisor function `baud_div(clk_hz, baud)`.
- One sub-module: `sync_fifo`, parametrised by `WIDTH` and `DEPTH`, exposing `push`, `pop`, `full`, `empty` and `count`. Reused later for the TX path.
- The receiver FSM, tick generator and synchroniser stay in the top module.

## Test plan
- Bench configuration: CLK_HZ = 50_000_000, BAUD = 3_125_000, so DIV = 1 and one bit = 16 clk.
1. 8N1, send 0x41 then 0x42 with `rx_ready` = 0. Expect `rx_count` = 2, `rx_data` = 0x41, `led` = 0x42. Pulse `rx_ready` once; expect `rx_data` = 0x42 and `rx_count` = 1.
2. PARITY = 2 (odd), DATA_BITS = 7. Send 0x55 with parity 1; expect a push. Send 0x55 with parity 0; expect `parity_err` = 1 and no push. Pulse `err_clear`; expect the flag at 0.
3. Drive `uart_rx` = 0 for 3 frame times, then release high. Expect exactly one `frame_err` and no push. Then send 0x3C; expect it received correctly.
4. FIFO_DEPTH = 4. Send 5 words 0x01..0x05 with `rx_ready` = 0. Expect `rx_count` = 4, `overrun` = 1, and the pop sequence 0x01..0x04.
5. Glitch test: drive a 4-cycle low pulse on `uart_rx`. Expect the FSM back in IDLE, no flags and no push.
6. Assert `reset` = 0 mid-DATA of 0xA5, release it, then send 0x5A. Expect all outputs 0 during reset and exactly one entry, 0x5A.
